// File: rtl/fb_triple_buf_ctrl.sv
// -----------------------------------------------------------------------------
// fb_triple_buf_ctrl
//
// Triple-buffer scheduler for a shared framebuffer BRAM holding three banks of
// FRAME_PIXELS words each (bank b starts at b*FRAME_PIXELS).
//
// The write side turns the incoming pixel stream into BRAM write strobes. The
// read side issues BRAM read addresses for the display path and produces FIFO
// write strobes aligned with the BRAM read data.
//
// Three bank roles are tracked: displayed (disp), being written (wbank) and
// completed-but-not-yet-shown (ready). The roles are always three distinct
// banks. Because of this the display never reads a bank that is being written.
//
// Optional feature: define FB_DROP_CNT_EN to add o_drop_cnt. This is a 16-bit
// saturating count of completed frames that were discarded before they could
// be shown. When the macro is not defined, the port and the counter do not
// exist and the scheduling is the same.
//
// Ports
//   i_clk         system clock
//   i_rstn        synchronous, active-low reset
//   i_wr_valid    pixel valid from preprocess
//   i_wr_sof      marks the valid pixel as the first pixel of a frame
//   i_wr_data     pixel data
//   o_wr          BRAM write enable
//   o_waddr       BRAM write address
//   o_wdata       BRAM write data, aligned with o_wr/o_waddr
//   i_req         display active; reading allowed
//   i_almostfull  output FIFO almost full; reading paused
//   o_raddr       BRAM read address (BRAM has 1-cycle read latency)
//   o_fifo_wr     FIFO write, aligned with BRAM read data
//   o_disp_bank   bank currently displayed (0..2)
//   o_frame_valid high once the first complete frame has been taken for display
//   o_drop_cnt    dropped-frame count (only with FB_DROP_CNT_EN)
// -----------------------------------------------------------------------------
module fb_triple_buf_ctrl #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_WIDTH   = $clog2(3*FRAME_PIXELS)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr_valid,
  input  logic                  i_wr_sof,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_req,
  input  logic                  i_almostfull,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic                  o_fifo_wr,
  output logic [1:0]            o_disp_bank,
  output logic                  o_frame_valid
`ifdef FB_DROP_CNT_EN
  ,
  output logic [15:0]           o_drop_cnt
`endif
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(FRAME_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] BASE2 = ADDR_WIDTH'(2 * FRAME_PIXELS);

  typedef enum logic {WR_WAIT_SOF, WR_ACTIVE} wr_state_t;
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_t;

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;

  // Bank roles. The ready bank always holds the third bank, even while
  // ready_valid is low. This keeps every role swap a simple exchange.
  logic [1:0] disp;
  logic [1:0] wbank;
  logic [1:0] ready;
  logic       ready_valid;

  logic       rd_vld_p0;

  logic wr_start;
  logic wr_cont;
  logic wr_done;
  logic rd_take;
  logic rd_issue;
  logic rd_wrap;
  logic rd_switch;

  // Bank base address. A constant mux is used, so no multiplier is needed.
  function automatic logic [ADDR_WIDTH-1:0] bank_base(input logic [1:0] b);
    logic [ADDR_WIDTH-1:0] base;
    case (b)
      2'd1:    base = BASE1;
      2'd2:    base = BASE2;
      default: base = '0;
    endcase
    return base;
  endfunction

  always_comb begin
    wr_start  = i_wr_valid && i_wr_sof;
    wr_cont   = i_wr_valid && !i_wr_sof && (wr_state == WR_ACTIVE);
    wr_done   = wr_cont && (wr_cnt == LAST_PIX);
    rd_take   = (rd_state == RD_IDLE) && ready_valid;
    rd_issue  = (rd_state == RD_ACTIVE) && i_req && !i_almostfull;
    rd_wrap   = rd_issue && (rd_cnt == LAST_PIX);
    // The display moves to a new bank at this point, if one is available.
    rd_switch = rd_take || rd_wrap;
  end

  // Write FSM. Outputs are registered, so a pixel appears on the BRAM port
  // one cycle after it is accepted. A sof pixel always restarts at offset 0.
  // This also discards a short frame that is still in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_state <= WR_WAIT_SOF;
      wr_cnt   <= '0;
      o_wr     <= 1'b0;
      o_waddr  <= '0;
      o_wdata  <= '0;
    end else begin
      o_wr <= wr_start || wr_cont;
      case (wr_state)
        WR_WAIT_SOF: begin
          if (wr_start) begin
            o_waddr  <= bank_base(wbank);
            o_wdata  <= i_wr_data;
            wr_cnt   <= CNT_W'(1);
            wr_state <= WR_ACTIVE;
          end
        end
        WR_ACTIVE: begin
          if (wr_start) begin
            o_waddr <= bank_base(wbank);
            o_wdata <= i_wr_data;
            wr_cnt  <= CNT_W'(1);
          end else if (wr_cont) begin
            o_waddr <= bank_base(wbank) + ADDR_WIDTH'(wr_cnt);
            o_wdata <= i_wr_data;
            if (wr_done) begin
              wr_cnt   <= '0;
              wr_state <= WR_WAIT_SOF;
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        default: wr_state <= WR_WAIT_SOF;
      endcase
    end
  end

  // Read FSM. The address is registered on issue. The FIFO strobe waits one
  // more stage, so it lines up with the BRAM read data.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_state      <= RD_IDLE;
      rd_cnt        <= '0;
      o_raddr       <= '0;
      rd_vld_p0     <= 1'b0;
      o_fifo_wr     <= 1'b0;
      o_frame_valid <= 1'b0;
    end else begin
      // stage p0: read address presented to BRAM
      rd_vld_p0 <= rd_issue;
      // stage p1: BRAM data valid, push into FIFO
      o_fifo_wr <= rd_vld_p0;
      case (rd_state)
        RD_IDLE: begin
          if (rd_take) begin
            o_frame_valid <= 1'b1;
            rd_state      <= RD_ACTIVE;
          end
        end
        RD_ACTIVE: begin
          if (rd_issue) begin
            o_raddr <= bank_base(disp) + ADDR_WIDTH'(rd_cnt);
            rd_cnt  <= rd_wrap ? '0 : rd_cnt + CNT_W'(1);
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Bank role exchange.
  // - Completion at the same time as a display switch: the fresh frame goes
  //   straight to the display, and the old display bank becomes the write
  //   bank. Any pending ready frame is lost.
  // - Completion alone: the fresh frame becomes ready, and writing continues
  //   in the previous ready bank. A pending ready frame is overwritten.
  // - Display switch with a ready frame: ready and disp exchange.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      disp        <= 2'd0;
      wbank       <= 2'd1;
      ready       <= 2'd2;
      ready_valid <= 1'b0;
    end else if (wr_done && rd_switch) begin
      disp        <= wbank;
      wbank       <= disp;
      ready_valid <= 1'b0;
    end else if (wr_done) begin
      ready       <= wbank;
      wbank       <= ready;
      ready_valid <= 1'b1;
    end else if (rd_switch && ready_valid) begin
      disp        <= ready;
      ready       <= disp;
      ready_valid <= 1'b0;
    end
  end

  assign o_disp_bank = disp;

`ifdef FB_DROP_CNT_EN
  // A completion that finds a frame still pending always discards that
  // frame. This is true whether or not the display switches in that cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_drop_cnt <= '0;
    end else if (wr_done && ready_valid && (o_drop_cnt != 16'hFFFF)) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_triple_buf_ctrl.sv
module tb_fb_triple_buf_ctrl;

  localparam int DW = 12;
  localparam int FP = 16;
  localparam int AW = $clog2(3*FP);

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_valid, wr_sof, req, afull;
  logic [DW-1:0] wr_data;
  logic          o_wr, o_fifo_wr, o_frame_valid;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [DW-1:0] o_wdata;
  logic [1:0]    o_disp_bank;
`ifdef FB_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  fb_triple_buf_ctrl #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_valid(wr_valid), .i_wr_sof(wr_sof), .i_wr_data(wr_data),
    .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_req(req), .i_almostfull(afull),
    .o_raddr(o_raddr), .o_fifo_wr(o_fifo_wr),
    .o_disp_bank(o_disp_bank), .o_frame_valid(o_frame_valid)
`ifdef FB_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model. Banks are plain integers and ready = -1 means no frame
  // is waiting. Addresses are computed as bank*FP + index.
  int m_disp, m_wbank, m_ready;
  int m_wcnt, m_rcnt, m_drop;
  bit m_in_frame, m_started, m_pend;
  int e_wr, e_waddr, e_wdata, e_raddr, e_fifo, e_fv;

  task automatic model_reset();
    m_disp = 0; m_wbank = 1; m_ready = -1;
    m_wcnt = 0; m_rcnt = 0; m_drop = 0;
    m_in_frame = 0; m_started = 0; m_pend = 0;
    e_wr = 0; e_waddr = 0; e_wdata = 0; e_raddr = 0; e_fifo = 0; e_fv = 0;
  endtask

  task automatic model_step();
    bit done, take, wrap, issue;
    int od, ow;
    if (!rstn) begin
      model_reset();
      return;
    end
    done = 0; take = 0; wrap = 0;
    e_wr = 0;
    if (wr_valid && wr_sof) begin
      e_wr = 1; e_waddr = m_wbank*FP; e_wdata = int'(wr_data);
      m_wcnt = 1; m_in_frame = 1;
    end else if (wr_valid && m_in_frame) begin
      e_wr = 1; e_waddr = m_wbank*FP + m_wcnt; e_wdata = int'(wr_data);
      if (m_wcnt == FP-1) begin
        done = 1; m_in_frame = 0; m_wcnt = 0;
      end else m_wcnt++;
    end
    issue = m_started && req && !afull;
    if (!m_started) take = (m_ready >= 0);
    else if (issue) begin
      e_raddr = m_disp*FP + m_rcnt;
      if (m_rcnt == FP-1) begin wrap = 1; m_rcnt = 0; end
      else m_rcnt++;
    end
    e_fifo = m_pend; m_pend = issue;
    od = m_disp; ow = m_wbank;
    if (done && (take || wrap)) begin
      if (m_ready >= 0) m_drop++;
      m_disp = ow; m_wbank = od; m_ready = -1;
    end else if (done) begin
      if (m_ready >= 0) m_drop++;
      m_ready = ow; m_wbank = 3 - od - ow;
    end else if ((take || wrap) && m_ready >= 0) begin
      m_disp = m_ready; m_ready = -1;
    end
    if (take) begin m_started = 1; e_fv = 1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wr", 32'(o_wr), e_wr);
    if (e_wr != 0) begin
      chk("waddr", 32'(o_waddr), e_waddr);
      chk("wdata", 32'(o_wdata), e_wdata);
    end
    chk("raddr", 32'(o_raddr), e_raddr);
    chk("fifo_wr", 32'(o_fifo_wr), e_fifo);
    chk("disp_bank", 32'(o_disp_bank), m_disp);
    chk("frame_valid", 32'(o_frame_valid), e_fv);
`ifdef FB_DROP_CNT_EN
    chk("drop_cnt", 32'(o_drop_cnt), m_drop);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic write_px(input int n, input bit sof_first);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1; wr_sof = sof_first && (k == 0); wr_data = DW'($urandom);
      tick();
    end
    wr_valid = 0; wr_sof = 0;
  endtask

  task automatic timeout(input string tag);
    n_assert++; n_fail++;
    $error("FAIL %s wait expired observed=timeout expected=event", tag);
  endtask

  task automatic do_reset();
    rstn = 0;
    repeat (3) tick();
    rstn = 1;
  endtask

  int old_disp, old_w, wb, cyc;

  initial begin
    rstn = 0; wr_valid = 0; wr_sof = 0; wr_data = '0; req = 1; afull = 0;
    model_reset();
    // Reset state, display requested with nothing written
    do_reset();
    chk("rst_wr", 32'(o_wr), 0);
    chk("rst_raddr", 32'(o_raddr), 0);
    repeat (20) tick();
    chk("idle_fifo_wr", 32'(o_fifo_wr), 0);
    chk("idle_frame_valid", 32'(o_frame_valid), 0);

    // One full frame into bank 1, then displayed
    write_px(FP, 1);
    repeat (40) tick();
    chk("frame1_disp", 32'(o_disp_bank), 1);
    chk("frame1_fv", 32'(o_frame_valid), 1);

    // Almost-full pause after address 23
    cyc = 0;
    while (!(m_rcnt == 8) && cyc < 100) begin tick(); cyc++; end
    if (cyc >= 100) timeout("af_wait");
    afull = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("af_hold", 32'(o_raddr), 23);
    end
    afull = 0;
    tick();
    chk("af_resume", 32'(o_raddr), 24);
    repeat (30) tick();

    // Three frames with display paused: one drop, newest frame shown next
    req = 0;
    do_reset();
    write_px(FP, 1); repeat (3) tick();
    write_px(FP, 1); repeat (3) tick();
    write_px(FP, 1); repeat (3) tick();
`ifdef FB_DROP_CNT_EN
    chk("drop3", 32'(o_drop_cnt), 1);
`endif
    req = 1;
    repeat (20) tick();
    chk("next_disp_last", 32'(o_disp_bank), 0);

    // Write completion and read wrap in the same cycle
    cyc = 0;
    while (!(m_started && m_rcnt == 0 && !m_in_frame) && cyc < 100) begin tick(); cyc++; end
    if (cyc >= 100) timeout("sim_wait");
    old_disp = m_disp; old_w = m_wbank;
    write_px(FP, 1);
    chk("sim_disp", 32'(o_disp_bank), old_w);
    wr_valid = 1; wr_sof = 1; wr_data = DW'($urandom);
    tick();
    wr_valid = 0; wr_sof = 0;
    chk("sim_wbank", 32'(o_waddr) / FP, old_disp);
    chk("sim_distinct", 32'(o_disp_bank != 2'(o_waddr / FP)), 1);
    repeat (5) tick();

    // Short frame restarted by sof at pixel 10
    wb = m_wbank;
    write_px(10, 1);
    wr_valid = 1; wr_sof = 1; wr_data = DW'($urandom);
    tick();
    chk("short_restart", 32'(o_waddr), wb*FP);
    write_px(FP-1, 0);
    repeat (40) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(3) != 0);
      wr_sof   = wr_valid && ($urandom_range(39) == 0);
      wr_data  = DW'($urandom);
      req      = ($urandom_range(7) != 0);
      afull    = ($urandom_range(5) == 0);
      tick();
    end
    wr_valid = 0; wr_sof = 0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
